// File: rtl/bus_sequencer_if.sv
// Control/status bundle between bus_sequencer and the datapath.
// master = sequencer side, slave = datapath / IR / memory side.
interface bus_sequencer_if;
  logic        start;
  logic [31:0] ir;
  logic        mem_done;
  logic [15:0] reg_out;
  logic [15:0] reg_in;
  logic        pc_out;
  logic        pc_in;
  logic        inc_pc;
  logic        mar_in;
  logic        read;
  logic        mdr_in;
  logic        mdr_out;
  logic        ir_in;
  logic        y_in;
  logic        z_in;
  logic        zlow_out;
  logic        zhigh_out;
  logic        lo_in;
  logic        hi_in;
  logic [4:0]  alu_op;
  logic        busy;
  logic        done;
  logic [1:0]  error;

  modport master (
    input  start, ir, mem_done,
    output reg_out, reg_in, pc_out, pc_in, inc_pc, mar_in,
    output read, mdr_in, mdr_out, ir_in,
    output y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in,
    output alu_op, busy, done, error
  );

  modport slave (
    output start, ir, mem_done,
    input  reg_out, reg_in, pc_out, pc_in, inc_pc, mar_in,
    input  read, mdr_in, mdr_out, ir_in,
    input  y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in,
    input  alu_op, busy, done, error
  );
endinterface

// File: rtl/bus_sequencer.sv
// Moore sequencer for fetch + reg-reg ALU execute on a single shared bus.
// Outputs decode from state only (mem_done gates mdr_in in T2).
module bus_sequencer #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 16
) (
  input  logic            clock,
  input  logic            reset,
  bus_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, DEC,
    T4, T5, T6, T7,
    FIN_OK, FIN_ILL, FIN_TO
  } state_t;

  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);

  state_t        state, nxt;
  logic [TW-1:0] cnt, cnt_nxt;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       legal;
  logic       is_mul;

  assign op = bus.ir[31:27];
  assign ra = bus.ir[26:23];
  assign rb = bus.ir[22:19];
  assign rc = bus.ir[18:15];

  always_comb begin
    legal  = 1'b0;
    is_mul = 1'b0;
    unique case (1'b1)
      (op == 5'b00011): legal = 1'b1;
      (op == 5'b00100): legal = 1'b1;
      (op == 5'b00101): legal = 1'b1;
      (op == 5'b00110): legal = 1'b1;
      (op == 5'b01111): begin
        legal  = 1'b1;
        is_mul = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    nxt           = state;
    cnt_nxt       = cnt;
    bus.reg_out   = '0;
    bus.reg_in    = '0;
    bus.pc_out    = 1'b0;
    bus.pc_in     = 1'b0;
    bus.inc_pc    = 1'b0;
    bus.mar_in    = 1'b0;
    bus.read      = 1'b0;
    bus.mdr_in    = 1'b0;
    bus.mdr_out   = 1'b0;
    bus.ir_in     = 1'b0;
    bus.y_in      = 1'b0;
    bus.z_in      = 1'b0;
    bus.zlow_out  = 1'b0;
    bus.zhigh_out = 1'b0;
    bus.lo_in     = 1'b0;
    bus.hi_in     = 1'b0;
    bus.alu_op    = '0;
    bus.busy      = (state != IDLE);
    bus.done      = 1'b0;
    bus.error     = 2'b00;
    unique case (state)
      IDLE: if (bus.start) nxt = T0;
      T0: begin
        bus.pc_out = 1'b1;
        bus.mar_in = 1'b1;
        bus.inc_pc = 1'b1;
        bus.z_in   = 1'b1;
        nxt        = T1;
      end
      T1: begin
        bus.zlow_out = 1'b1;
        bus.pc_in    = 1'b1;
        cnt_nxt      = '0;
        nxt          = T2;
      end
      T2: begin
        bus.read = 1'b1;
        // a late mem_done still beats the timeout
        if (bus.mem_done) begin
          bus.mdr_in = 1'b1;
          nxt        = T3;
        end else if (cnt == LIMIT) begin
          nxt = FIN_TO;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      T3: begin
        bus.mdr_out = 1'b1;
        bus.ir_in   = 1'b1;
        nxt         = DEC;
      end
      DEC: nxt = legal ? T4 : FIN_ILL;
      T4: begin
        bus.reg_out = 16'h1 << rb;
        bus.y_in    = 1'b1;
        nxt         = T5;
      end
      T5: begin
        bus.reg_out = 16'h1 << rc;
        bus.z_in    = 1'b1;
        bus.alu_op  = op;
        nxt         = T6;
      end
      T6: begin
        bus.zlow_out = 1'b1;
        if (is_mul) begin
          bus.lo_in = 1'b1;
          nxt       = T7;
        end else begin
          bus.reg_in = 16'h1 << ra;
          nxt        = FIN_OK;
        end
      end
      T7: begin
        bus.zhigh_out = 1'b1;
        bus.hi_in     = 1'b1;
        nxt           = FIN_OK;
      end
      FIN_OK, FIN_ILL, FIN_TO: begin
        bus.done  = 1'b1;
        bus.error = (state == FIN_ILL) ? 2'b01 :
                    (state == FIN_TO)  ? 2'b10 : 2'b00;
        nxt       = bus.start ? T0 : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// Randomized bench for bus_sequencer against a per-instruction
// expected-cycle-list model built from the sequencing rules.
module tb_bus_sequencer;

  localparam int TO = 4;

  typedef struct packed {
    logic [15:0] reg_out;
    logic [15:0] reg_in;
    logic pc_out, pc_in, inc_pc, mar_in;
    logic read, mdr_in, mdr_out, ir_in;
    logic y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in;
    logic [4:0] alu_op;
    logic busy, done;
    logic [1:0] error;
  } ov_t;

  logic clock;
  logic reset;
  int   checks;
  int   passes;

  ov_t exp_q[$];
  int  md_q[$];

  bus_sequencer_if bus ();

  bus_sequencer #(.TIMEOUT(TO), .TW(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic ov_t pack();
    ov_t v;
    v.reg_out   = bus.reg_out;
    v.reg_in    = bus.reg_in;
    v.pc_out    = bus.pc_out;
    v.pc_in     = bus.pc_in;
    v.inc_pc    = bus.inc_pc;
    v.mar_in    = bus.mar_in;
    v.read      = bus.read;
    v.mdr_in    = bus.mdr_in;
    v.mdr_out   = bus.mdr_out;
    v.ir_in     = bus.ir_in;
    v.y_in      = bus.y_in;
    v.z_in      = bus.z_in;
    v.zlow_out  = bus.zlow_out;
    v.zhigh_out = bus.zhigh_out;
    v.lo_in     = bus.lo_in;
    v.hi_in     = bus.hi_in;
    v.alu_op    = bus.alu_op;
    v.busy      = bus.busy;
    v.done      = bus.done;
    v.error     = bus.error;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // md_q: 0/1 = mem_done in a T2 cycle, 2 = don't care (randomized)
  task automatic push(input ov_t v, input int md);
    exp_q.push_back(v);
    md_q.push_back(md);
  endtask

  task automatic build(input logic [31:0] instr, input int delay);
    ov_t v;
    logic [4:0] op;
    bit legal, mul;
    op = instr[31:27];
    mul = (op == 5'd15);
    legal = (op == 5'd3) || (op == 5'd4) || (op == 5'd5) ||
            (op == 5'd6) || mul;
    exp_q.delete();
    md_q.delete();
    v = '0; v.busy = 1; v.pc_out = 1; v.mar_in = 1;
    v.inc_pc = 1; v.z_in = 1;
    push(v, 2);
    v = '0; v.busy = 1; v.zlow_out = 1; v.pc_in = 1;
    push(v, 2);
    if (delay >= TO) begin
      for (int i = 0; i < TO; i++) begin
        v = '0; v.busy = 1; v.read = 1;
        push(v, 0);
      end
      v = '0; v.busy = 1; v.done = 1; v.error = 2'b10;
      push(v, 2);
      return;
    end
    for (int i = 0; i < delay; i++) begin
      v = '0; v.busy = 1; v.read = 1;
      push(v, 0);
    end
    v = '0; v.busy = 1; v.read = 1; v.mdr_in = 1;
    push(v, 1);
    v = '0; v.busy = 1; v.mdr_out = 1; v.ir_in = 1;
    push(v, 2);
    v = '0; v.busy = 1;
    push(v, 2);
    if (!legal) begin
      v = '0; v.busy = 1; v.done = 1; v.error = 2'b01;
      push(v, 2);
      return;
    end
    v = '0; v.busy = 1; v.y_in = 1;
    v.reg_out = 16'(1 << instr[22:19]);
    push(v, 2);
    v = '0; v.busy = 1; v.z_in = 1; v.alu_op = op;
    v.reg_out = 16'(1 << instr[18:15]);
    push(v, 2);
    v = '0; v.busy = 1; v.zlow_out = 1;
    if (mul) v.lo_in = 1;
    else v.reg_in = 16'(1 << instr[26:23]);
    push(v, 2);
    if (mul) begin
      v = '0; v.busy = 1; v.zhigh_out = 1; v.hi_in = 1;
      push(v, 2);
    end
    v = '0; v.busy = 1; v.done = 1;
    push(v, 2);
  endtask

  task automatic one_drv(input string tag);
    int n;
    n = $countones({bus.reg_out, bus.pc_out, bus.mdr_out,
                    bus.zlow_out, bus.zhigh_out});
    chk({tag, "_onedrv"}, 64'(n <= 1), 64'd1);
  endtask

  task automatic run(input string tag, input logic [31:0] instr,
                     input int delay, input bit started,
                     input bit chain);
    int n;
    build(instr, delay);
    bus.ir = instr;
    if (!started) begin
      bus.start = 1'b1;
      tick();
    end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      bus.mem_done = (md_q[i] == 2) ? 1'($urandom_range(0, 1))
                                    : 1'(md_q[i]);
      bus.start = (i == n - 1) ? chain : 1'($urandom_range(0, 1));
      @(negedge clock);
      chk($sformatf("%s_c%0d", tag, i), 64'(pack()), 64'(exp_q[i]));
      one_drv(tag);
      tick();
    end
    bus.start = 1'b0;
    bus.mem_done = 1'b0;
    if (!chain) begin
      @(negedge clock);
      chk({tag, "_idle"}, 64'(pack()), 64'd0);
      tick();
    end
  endtask

  initial begin
    logic [31:0] instr;
    logic [4:0]  ops [5];
    bit chain, started;
    checks = 0;
    passes = 0;
    ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd15};
    reset = 1'b1;
    bus.start = 1'b0;
    bus.ir = '0;
    bus.mem_done = 1'b0;
    @(negedge clock);
    chk("reset_state", 64'(pack()), 64'd0);
    tick();
    reset = 1'b0;
    tick();

    run("add", 32'h19908000, 0, 0, 0);
    run("mul", 32'h7A208000, 0, 0, 0);
    run("add_wait3", 32'h19908000, 3, 0, 0);
    run("timeout", 32'h19908000, 99, 0, 0);
    run("illegal", 32'hF8000000, 0, 0, 0);
    run("chain_a", 32'h19908000, 1, 0, 1);
    run("chain_b", 32'h7A208000, 0, 1, 0);

    // abort mid-T5 with an asynchronous reset
    bus.ir = 32'h19908000;
    bus.mem_done = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (6) tick();
    @(negedge clock);
    chk("rst_in_t5", 64'({bus.z_in, bus.alu_op}), 64'({1'b1, 5'd3}));
    #1 reset = 1'b1;
    #1 chk("rst_async", 64'(pack()), 64'd0);
    tick();
    chk("rst_held", 64'(pack()), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk($sformatf("rst_idle%0d", i), 64'(pack()), 64'd0);
      tick();
    end
    bus.mem_done = 1'b0;

    started = 0;
    for (int k = 0; k < 24; k++) begin
      instr = $urandom;
      if ($urandom_range(0, 9) < 7)
        instr[31:27] = ops[$urandom_range(0, 4)];
      chain = (k == 23) ? 1'b0 : 1'($urandom_range(0, 1));
      run($sformatf("rnd%0d", k), instr, $urandom_range(0, 5),
          started, chain);
      started = chain;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
